// File: rtl/sha1_block_decode_pkg.sv
// Shared constants and types for the SHA1 block decoder.
package sha1_block_decode_pkg;

  localparam logic [31:0] SHA1_PAD_WORD    = 32'h8000_0000;
  localparam int unsigned SHA1_BLOCK_WORDS = 16;
  localparam int unsigned NONCE_DIGITS     = 15;
  localparam int unsigned FIXED_BYTES      = 7;
  localparam int unsigned IDX_W            = $clog2(SHA1_BLOCK_WORDS);

  // Word positions within the 16-word block
  localparam logic [IDX_W-1:0] W_NONCE0 = IDX_W'(0);
  localparam logic [IDX_W-1:0] W_NONCE1 = IDX_W'(1);
  localparam logic [IDX_W-1:0] W_NONCE2 = IDX_W'(2);
  localparam logic [IDX_W-1:0] W_NONCE3 = IDX_W'(3);
  localparam logic [IDX_W-1:0] W_FIXED0 = IDX_W'(4);
  localparam logic [IDX_W-1:0] W_FIXED1 = IDX_W'(5);
  localparam logic [IDX_W-1:0] W_PAD    = IDX_W'(6);
  localparam logic [IDX_W-1:0] W_LEN    = IDX_W'(15);

  typedef enum logic {
    ST_COLLECT,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/sha1_block_decode_if.sv
// Word-in / result-out bus of the SHA1 block decoder.
interface sha1_block_decode_if;
  import sha1_block_decode_pkg::*;

  logic                         rx_valid;
  logic                         rx_ready;
  logic                         rx_sof;
  logic [31:0]                  rx_word;
  logic                         tx_valid;
  logic                         tx_ready;
  logic [4*NONCE_DIGITS-1:0]    tx_nonce;
  logic [8*FIXED_BYTES-1:0]     tx_fixed_data;
  logic                         tx_digit_err;
  logic                         tx_pad_err;
  logic                         sync_drop;

  // Block source / result consumer side
  modport master (
    output rx_valid, rx_sof, rx_word, tx_ready,
    input  rx_ready, tx_valid, tx_nonce, tx_fixed_data,
           tx_digit_err, tx_pad_err, sync_drop
  );

  // Decoder side
  modport slave (
    input  rx_valid, rx_sof, rx_word, tx_ready,
    output rx_ready, tx_valid, tx_nonce, tx_fixed_data,
           tx_digit_err, tx_pad_err, sync_drop
  );

endinterface

// File: rtl/sha1_block_decode_bcd.sv
// Splits a word into four BCD digit nibbles (MSB byte first) and flags
// each byte that is not a valid {4'b0, digit} encoding.
module bcd_byte_check (
  input  logic [31:0] word,
  output logic [15:0] digits,
  output logic [3:0]  bad
);

  // Per-byte digit extraction and range check
  always_comb begin
    for (int unsigned b = 0; b < 4; b++) begin
      digits[4*b +: 4] = word[8*b +: 4];
      bad[b]           = (word[8*b+4 +: 4] != 4'h0) || (word[8*b +: 4] > 4'd9);
    end
  end

endmodule

// File: rtl/sha1_block_decode.sv
// Recovers the BCD nonce and fixed data from a serial 16-word SHA1 block,
// flags digit/padding errors and holds the result until it is consumed.
module sha1_block_decode
  import sha1_block_decode_pkg::*;
#(
  parameter int unsigned LEN_BITS  = 192,
  parameter bit          CHECK_PAD = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  sha1_block_decode_if.slave bus
);

  localparam logic [31:0] LEN_WORD = 32'(LEN_BITS);

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          eff_idx;
  logic [4*NONCE_DIGITS-1:0] nonce_sh, nonce_nx, tx_nonce_q;
  logic [8*FIXED_BYTES-1:0]  fixed_sh, fixed_nx, tx_fixed_q;
  logic                      digit_acc, digit_nx, pad_acc, pad_nx;
  logic                      rx_ready_q, tx_valid_q, tx_digit_err_q, tx_pad_err_q, sync_drop_q;
  logic                      xfer, stray;
  logic [15:0]               digits;
  logic [3:0]                byte_bad;

  bcd_byte_check u_bcd (
    .word   (bus.rx_word),
    .digits (digits),
    .bad    (byte_bad)
  );

  assign xfer  = bus.rx_valid && rx_ready_q;
  assign stray = xfer && !bus.rx_sof && (idx == W_NONCE0);

  // Next shadow/accumulator values if the current word is accepted; a
  // start-of-frame word restarts from cleared state so clear and load merge.
  always_comb begin
    eff_idx  = bus.rx_sof ? W_NONCE0 : idx;
    nonce_nx = bus.rx_sof ? '0 : nonce_sh;
    fixed_nx = bus.rx_sof ? '0 : fixed_sh;
    digit_nx = bus.rx_sof ? 1'b0 : digit_acc;
    pad_nx   = bus.rx_sof ? 1'b0 : pad_acc;
    case (eff_idx)
      W_NONCE0: begin
        nonce_nx[59:44] = digits;
        digit_nx        = digit_nx | (|byte_bad);
      end
      W_NONCE1: begin
        nonce_nx[43:28] = digits;
        digit_nx        = digit_nx | (|byte_bad);
      end
      W_NONCE2: begin
        nonce_nx[27:12] = digits;
        digit_nx        = digit_nx | (|byte_bad);
      end
      W_NONCE3: begin
        nonce_nx[11:0] = digits[15:4];
        digit_nx       = digit_nx | (|byte_bad[3:1]);
        pad_nx         = pad_nx | (bus.rx_word[7:0] != 8'h00);
      end
      W_FIXED0: fixed_nx[55:24] = bus.rx_word;
      W_FIXED1: begin
        fixed_nx[23:0] = bus.rx_word[31:8];
        pad_nx         = pad_nx | (bus.rx_word[7:0] != 8'h00);
      end
      W_PAD:   pad_nx = pad_nx | (bus.rx_word != SHA1_PAD_WORD);
      W_LEN:   pad_nx = pad_nx | (bus.rx_word != LEN_WORD);
      default: pad_nx = pad_nx | (bus.rx_word != '0);
    endcase
  end

  // Collect/hold FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_COLLECT;
      idx            <= W_NONCE0;
      nonce_sh       <= '0;
      fixed_sh       <= '0;
      digit_acc      <= 1'b0;
      pad_acc        <= 1'b0;
      rx_ready_q     <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_nonce_q     <= '0;
      tx_fixed_q     <= '0;
      tx_digit_err_q <= 1'b0;
      tx_pad_err_q   <= 1'b0;
      sync_drop_q    <= 1'b0;
    end else begin
      sync_drop_q <= 1'b0;
      unique case (state)
        ST_COLLECT: begin
          rx_ready_q <= 1'b1;
          if (stray) begin
            sync_drop_q <= 1'b1;
          end else if (xfer) begin
            nonce_sh    <= nonce_nx;
            fixed_sh    <= fixed_nx;
            digit_acc   <= digit_nx;
            pad_acc     <= pad_nx;
            sync_drop_q <= bus.rx_sof && (idx != W_NONCE0);
            if (eff_idx == W_LEN) begin
              state          <= ST_HOLD;
              idx            <= W_NONCE0;
              rx_ready_q     <= 1'b0;
              tx_valid_q     <= 1'b1;
              tx_nonce_q     <= nonce_nx;
              tx_fixed_q     <= fixed_nx;
              tx_digit_err_q <= digit_nx;
              tx_pad_err_q   <= CHECK_PAD & pad_nx;
            end else begin
              idx <= eff_idx + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.tx_ready) begin
            state      <= ST_COLLECT;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.tx_nonce      = tx_nonce_q;
  assign bus.tx_fixed_data = tx_fixed_q;
  assign bus.tx_digit_err  = tx_digit_err_q;
  assign bus.tx_pad_err    = tx_pad_err_q;
  assign bus.sync_drop     = sync_drop_q;

endmodule

// File: tb/tb_sha1_block_decode.sv
// Testbench for sha1_block_decode: table vectors, randomized blocks against
// a byte-stream reference model, and handshake/sync/reset sequences.
module tb_sha1_block_decode;
  import sha1_block_decode_pkg::*;

  typedef logic [31:0] block_t [16];

  typedef struct packed {
    logic [59:0] n;
    logic [55:0] f;
    logic        de;
    logic        pe;
  } res_t;

  typedef struct {
    logic [59:0] nonce;
    logic [55:0] fixed;
    int unsigned cw;     // word to overwrite, 16 = none
    logic [31:0] cv;
    res_t        exp;
  } vec_t;

  localparam logic [31:0] LEN = 32'd192;
  localparam logic [59:0] N0  = 60'h000000509803065;
  localparam logic [55:0] F0  = 56'h35691903801083;
  localparam logic [59:0] N1  = 60'h123456789012345;
  localparam logic [55:0] F1  = 56'hDEADBEEF012345;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   drop_cnt = 0;

  always #5 clk = ~clk;

  sha1_block_decode_if bif ();
  sha1_block_decode_if bif0 ();

  sha1_block_decode #(.LEN_BITS(192), .CHECK_PAD(1'b1)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bif)
  );
  sha1_block_decode #(.LEN_BITS(192), .CHECK_PAD(1'b0)) dut_nopad (
    .clk (clk), .rst_n (rst_n), .bus (bif0)
  );

  assign bif0.rx_valid = bif.rx_valid;
  assign bif0.rx_sof   = bif.rx_sof;
  assign bif0.rx_word  = bif.rx_word;
  assign bif0.tx_ready = bif.tx_ready;

  always @(negedge clk) if (bif.sync_drop === 1'b1) drop_cnt <= drop_cnt + 1;

  // ---------------- reference model (byte-stream view) ----------------
  function automatic logic [7:0] pad_byte(input int j);
    logic [31:0] len;
    len = LEN;
    if (j == 24) return 8'h80;
    if (j >= 60) return len[8*(63-j) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] byte_of(input block_t blk, input int j);
    logic [31:0] w;
    w = blk[j/4];
    return w[31-8*(j%4) -: 8];
  endfunction

  function automatic block_t encode(input logic [59:0] nonce, input logic [55:0] fixed);
    logic [7:0] b [64];
    block_t     blk;
    for (int j = 0; j < 64; j++) b[j] = pad_byte(j);
    for (int d = 0; d < 15; d++) b[14-d] = {4'h0, nonce[4*d +: 4]};
    for (int k = 0; k < 7; k++)  b[22-k] = fixed[8*k +: 8];
    for (int w = 0; w < 16; w++) blk[w] = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
    return blk;
  endfunction

  function automatic res_t model(input block_t blk);
    res_t r;
    logic [7:0] b;
    r = '0;
    for (int d = 0; d < 15; d++) begin
      b = byte_of(blk, 14-d);
      r.n[4*d +: 4] = b[3:0];
      if (b > 8'd9) r.de = 1'b1;
    end
    for (int k = 0; k < 7; k++) r.f[8*k +: 8] = byte_of(blk, 22-k);
    for (int j = 0; j < 64; j++)
      if ((j == 15 || j >= 23) && byte_of(blk, j) != pad_byte(j)) r.pe = 1'b1;
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic sof);
    int unsigned n;
    n = 0;
    bif.rx_valid = 1'b1;
    bif.rx_word  = w;
    bif.rx_sof   = sof;
    while (!bif.rx_ready && n < 50) begin
      step();
      n++;
    end
    if (!bif.rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    step();
    bif.rx_valid = 1'b0;
    bif.rx_sof   = 1'b0;
  endtask

  task automatic send_block(input block_t blk, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step();
      if (i == 15) check("early_valid", 64'(bif.tx_valid), 64'd0);
      send_word(blk[i], (i == 0));
    end
  endtask

  task automatic expect_result(input string tag, input res_t e);
    check({tag, "_valid"},  64'(bif.tx_valid),      64'd1);
    check({tag, "_nonce"},  64'(bif.tx_nonce),      64'(e.n));
    check({tag, "_fixed"},  64'(bif.tx_fixed_data), 64'(e.f));
    check({tag, "_digit"},  64'(bif.tx_digit_err),  64'(e.de));
    check({tag, "_pad"},    64'(bif.tx_pad_err),    64'(e.pe));
    check({tag, "_pad_nochk"}, 64'(bif0.tx_pad_err), 64'd0);
    check({tag, "_nonce_nochk"}, 64'(bif0.tx_nonce), 64'(e.n));
  endtask

  task automatic release_result(input int unsigned wait_cycles);
    repeat (wait_cycles) step();
    bif.tx_ready = 1'b1;
    step();
    bif.tx_ready = 1'b0;
    check("released", 64'(bif.tx_valid), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t        vecs [10];
    block_t      blk, blk2;
    res_t        e, e2;
    logic [59:0] rn;
    logic [63:0] r64;
    int          d0;
    int unsigned j;

    vecs[0] = '{N0, F0, 16, 32'h0,          '{N0, F0, 1'b0, 1'b0}};
    vecs[1] = '{N0, F0, 1,  32'h000A0102,   '{60'h00000A129803065, F0, 1'b1, 1'b0}};
    vecs[2] = '{N0, F0, 15, 32'd200,        '{N0, F0, 1'b0, 1'b1}};
    vecs[3] = '{N0, F0, 9,  32'h1,          '{N0, F0, 1'b0, 1'b1}};
    vecs[4] = '{N0, F0, 3,  32'h00060501,   '{N0, F0, 1'b0, 1'b1}};
    vecs[5] = '{N0, F0, 5,  32'h80108355,   '{N0, F0, 1'b0, 1'b1}};
    vecs[6] = '{N0, F0, 6,  32'h0,          '{N0, F0, 1'b0, 1'b1}};
    vecs[7] = '{N1, F1, 16, 32'h0,          '{N1, F1, 1'b0, 1'b0}};
    vecs[8] = '{N0, F0, 0,  32'h10000000,   '{N0, F0, 1'b1, 1'b0}};
    vecs[9] = '{N0, F0, 2,  32'h090F0003,   '{60'h000000509F03065, F0, 1'b1, 1'b0}};

    bif.rx_valid = 1'b0;
    bif.rx_sof   = 1'b0;
    bif.rx_word  = '0;
    bif.tx_ready = 1'b0;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  64'(bif.tx_valid),      64'd0);
    check("rst_ready",  64'(bif.rx_ready),      64'd0);
    check("rst_nonce",  64'(bif.tx_nonce),      64'd0);
    check("rst_fixed",  64'(bif.tx_fixed_data), 64'd0);
    check("rst_derr",   64'(bif.tx_digit_err),  64'd0);
    check("rst_perr",   64'(bif.tx_pad_err),    64'd0);
    check("rst_drop",   64'(bif.sync_drop),     64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 64'(bif.rx_ready), 64'd1);

    // table vectors
    for (int i = 0; i < 10; i++) begin
      blk = encode(vecs[i].nonce, vecs[i].fixed);
      if (vecs[i].cw < 16) blk[vecs[i].cw] = vecs[i].cv;
      send_block(blk, 1'b0);
      expect_result($sformatf("vec%0d", i), vecs[i].exp);
      release_result(i % 3);
    end

    // HOLD stall with a new block waiting, then back-to-back decode
    d0   = drop_cnt;
    blk  = encode(N0, F0);
    blk2 = encode(N1, F1);
    send_block(blk, 1'b0);
    e = '{N0, F0, 1'b0, 1'b0};
    bif.rx_valid = 1'b1;
    bif.rx_sof   = 1'b1;
    bif.rx_word  = blk2[0];
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("stall%0d_ready", c), 64'(bif.rx_ready), 64'd0);
      check($sformatf("stall%0d_valid", c), 64'(bif.tx_valid), 64'd1);
      check($sformatf("stall%0d_nonce", c), 64'(bif.tx_nonce), 64'(e.n));
      check($sformatf("stall%0d_fixed", c), 64'(bif.tx_fixed_data), 64'(e.f));
    end
    bif.tx_ready = 1'b1;
    step();
    bif.tx_ready = 1'b0;
    check("stall_release_valid", 64'(bif.tx_valid), 64'd0);
    check("stall_release_ready", 64'(bif.rx_ready), 64'd1);
    step();
    bif.rx_valid = 1'b0;
    bif.rx_sof   = 1'b0;
    for (int i = 1; i < 16; i++) send_word(blk2[i], 1'b0);
    expect_result("b2b", '{N1, F1, 1'b0, 1'b0});
    release_result(0);
    check("stall_no_drop", 64'(drop_cnt - d0), 64'd0);

    // rx_sof re-asserted at index 7
    d0 = drop_cnt;
    for (int i = 0; i < 7; i++) send_word(blk2[i], (i == 0));
    send_block(blk, 1'b0);
    expect_result("resync", '{N0, F0, 1'b0, 1'b0});
    release_result(1);
    check("resync_drop", 64'(drop_cnt - d0), 64'd1);

    // stray word at index 0
    d0 = drop_cnt;
    send_word(32'hCAFEF00D, 1'b0);
    check("stray_pulse", 64'(bif.sync_drop), 64'd1);
    step();
    check("stray_pulse_end", 64'(bif.sync_drop), 64'd0);
    send_block(blk2, 1'b0);
    expect_result("stray", '{N1, F1, 1'b0, 1'b0});
    release_result(0);
    check("stray_drop", 64'(drop_cnt - d0), 64'd1);

    // asynchronous reset at index 9
    for (int i = 0; i < 9; i++) send_word(blk[i], (i == 0));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_nonce", 64'(bif.tx_nonce),      64'd0);
    check("mid_rst_fixed", 64'(bif.tx_fixed_data), 64'd0);
    check("mid_rst_ready", 64'(bif.rx_ready),      64'd0);
    check("mid_rst_valid", 64'(bif.tx_valid),      64'd0);
    step();
    step();
    check("mid_rst_drop",  64'(bif.sync_drop),     64'd0);
    rst_n = 1'b1;
    d0 = drop_cnt;
    step();
    send_block(blk2, 1'b0);
    expect_result("after_rst", '{N1, F1, 1'b0, 1'b0});
    release_result(0);
    check("after_rst_drop", 64'(drop_cnt - d0), 64'd0);

    // randomized blocks against the reference model
    for (int t = 0; t < 30; t++) begin
      for (int d = 0; d < 15; d++) rn[4*d +: 4] = 4'($urandom_range(0, 9));
      r64 = {$urandom(), $urandom()};
      blk = encode(rn, r64[55:0]);
      if ($urandom_range(0, 2) == 0) begin
        j = $urandom_range(0, 63);
        blk[j/4] = blk[j/4] ^ (32'($urandom_range(1, 255)) << (8 * (3 - j % 4)));
      end
      if ($urandom_range(0, 4) == 0) begin
        j = $urandom_range(0, 63);
        blk[j/4] = blk[j/4] ^ (32'($urandom_range(1, 255)) << (8 * (3 - j % 4)));
      end
      e2 = model(blk);
      send_block(blk, 1'b1);
      expect_result($sformatf("rnd%0d", t), e2);
      release_result($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha1_block_decode.md
Name: sha1_block_decode

Overview:
- Inverse of the message expander: accepts a 512-bit SHA1 block as 16 serial 32-bit words and recovers the 15-digit BCD nonce and the 56-bit fixed data.
- Checks digit encoding and padding, then presents the result with a valid/ready handshake.
- Used on the host/debug path to decode candidate blocks before re-hashing, and to self-check expander output.

Parameters:
- LEN_BITS, 192, expected message length in word 15.
- CHECK_PAD, 1, when 0 the pad_err flag is forced to 0.

Ports:
- clk  in  1  hash clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_valid  in  1  rx_word/rx_sof valid.
- rx_ready  out  1  block accepts word.
- rx_sof  in  1  marks word 0 of a block.
- rx_word  in  32  block word w = bits [32w+31:32w], sent w=0 first.
- tx_valid  out  1  decoded result valid.
- tx_ready  in  1  consumer accepts result.
- tx_nonce  out  60  BCD nonce, digit d in bits [4d+3:4d].
- tx_fixed_data  out  56  fixed data, byte b in bits [8b+7:8b].
- tx_digit_err  out  1  any nonce byte > 0x09.
- tx_pad_err  out  1  padding/length mismatch.
- sync_drop  out  1  one-cycle pulse: partial block or stray word discarded.

Behaviour:
- Word layout, all bytes MSB-first:
  - w0 = {n14,n13,n12,n11}; w1 = {n10..n7}; w2 = {n6..n3}; w3 = {n2,n1,n0,8'h00}.
  - w4 = {f6,f5,f4,f3}; w5 = {f2,f1,f0,8'h00}.
  - w6 = 32'h80000000; w7..w14 = 0; w15 = LEN_BITS.
  - Each nonce byte is {4'b0, digit}.
- States:
  - COLLECT: rx_ready=1; word index 0..15.
  - HOLD: rx_ready=0, tx_valid=1.
- Transfer occurs when rx_valid and rx_ready are both high.
- Synchronisation rules:
  - Transfer with rx_sof=1 at any index: index restarts at 0 with this word; clear error accumulators and the nonce/fixed shadow registers; if the old index was non-zero, pulse sync_drop.
  - Transfer at index 0 with rx_sof=0: word discarded, pulse sync_drop, index stays 0.
- Per accepted word:
  - Load the corresponding shadow register fields.
  - Digit error: any nonce byte with upper nibble non-zero or low nibble > 9 sets digit_err_acc.
  - Pad error: mismatch of a fixed byte/word (w3[7:0], w5[7:0], w6..w15) sets pad_err_acc.
- Index 15 accepted: next cycle state = HOLD; tx_* registered from the shadows/accumulators, including the w15 checks.
- Latency: tx_valid rises on the cycle after the w15 transfer.
- HOLD: outputs stable until tx_valid and tx_ready are both high; then return to COLLECT at index 0. Back-to-back blocks are possible: word 0 of the next block is accepted on the cycle after the release.
- rx_valid in HOLD is ignored (not accepted, no sync_drop).
- Reset (async, mid-operation included):
  - State COLLECT, index 0, all accumulators cleared.
  - tx_valid=0, tx_nonce=0, tx_fixed_data=0, tx_*_err=0, sync_drop=0, rx_ready=0 during reset then 1.
- Errors never block delivery; the result is always produced with its flags.

Decomposition:
- Shared package holds:
  - Constants SHA1_PAD_WORD=32'h80000000, SHA1_BLOCK_WORDS=16, NONCE_DIGITS=15, FIXED_BYTES=7.
  - Word-index constants W_NONCE0..W_LEN.
- One natural sub-module, bcd_byte_check: 32-bit word to 4 digit nibbles plus a bad-flag (combinational, instanced once).

Test Plan:
- Block with nonce 000000509803065, fixed 56'h35691903801083, LEN=192, sent with no gaps -> tx_valid 1 cycle after w15; tx_nonce=60'h000000509803065, tx_fixed_data=56'h35691903801083, both errors 0.
- Same block, tx_ready held low 10 cycles, then rx_valid with a new block -> outputs stable, rx_ready=0, no words accepted; after release the second block decodes correctly.
- w1 = 32'h000A0102 -> tx_digit_err=1, tx_pad_err=0, tx_nonce still delivered.
- w15 = 200, or w9 = 1, or w3[7:0] = 8'h01 -> tx_pad_err=1; repeat with CHECK_PAD=0 -> tx_pad_err=0.
- rx_sof re-asserted at index 7 followed by a full valid block -> sync_drop pulses once, result equals the second block; a word with rx_sof=0 at index 0 -> sync_drop, ignored.
- rst_n dropped at index 9 and released, then a full block -> outputs zero during reset, the subsequent block decodes cleanly with no sync_drop.
